// File: rtl/m_cntdn_timer.sv
// BCD mm:ss countdown timer: loads a saturated preset, counts down once per clk_sec edge
// while running, pulses borrow_min on each seconds wrap, and raises done/alarm at 00:00.
module m_cntdn_timer #(
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic       clk_sec,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] min_high_in,
  input  logic [3:0] min_low_in,
  input  logic [3:0] sec_high_in,
  input  logic [3:0] sec_low_in,
  output logic [3:0] min_high,
  output logic [3:0] min_low,
  output logic [3:0] sec_high,
  output logic [3:0] sec_low,
  output logic       borrow_min,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  localparam logic [3:0] AlarmInit = 4'(ALARM_SECS - 1);

  state_e     state_q, state_d;
  logic [3:0] mh_q, mh_d, ml_q, ml_d, sh_q, sh_d, sl_q, sl_d;
  logic       borrow_q, borrow_d;
  logic       alarm_q, alarm_d;
  logic [3:0] acnt_q, acnt_d;
  logic       count_zero;

  function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  assign count_zero = ({mh_q, ml_q, sh_q, sl_q} == 16'h0000);

  always_comb begin
    state_d  = state_q;
    mh_d     = mh_q;
    ml_d     = ml_q;
    sh_d     = sh_q;
    sl_d     = sl_q;
    borrow_d = 1'b0;
    alarm_d  = alarm_q;
    acnt_d   = acnt_q;
    if (load) begin
      state_d = StIdle;
      mh_d    = sat(min_high_in, 4'd5);
      ml_d    = sat(min_low_in, 4'd9);
      sh_d    = sat(sec_high_in, 4'd5);
      sl_d    = sat(sec_low_in, 4'd9);
      alarm_d = 1'b0;
      acnt_d  = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !count_zero) state_d = StRun;
        end
        StRun: begin
          if (pause) begin
            state_d = StPause;
          end else if (count_zero) begin
            // Defensive only: RUN is never entered with a zero count.
            state_d = StDone;
            alarm_d = 1'b1;
            acnt_d  = AlarmInit;
          end else begin
            if (sl_q != 4'd0) begin
              sl_d = sl_q - 4'd1;
            end else begin
              sl_d = 4'd9;
              if (sh_q != 4'd0) begin
                sh_d = sh_q - 4'd1;
              end else begin
                sh_d     = 4'd5;
                borrow_d = 1'b1;
                if (ml_q != 4'd0) begin
                  ml_d = ml_q - 4'd1;
                end else begin
                  ml_d = 4'd9;
                  mh_d = mh_q - 4'd1;
                end
              end
            end
            if ({mh_d, ml_d, sh_d, sl_d} == 16'h0000) begin
              state_d = StDone;
              alarm_d = 1'b1;
              acnt_d  = AlarmInit;
            end
          end
        end
        StPause: begin
          if (start) state_d = StRun;
        end
        StDone: begin
          // Entry edge already counted; alarm drops once the counter is exhausted.
          if (acnt_q != 4'd0) acnt_d = acnt_q - 4'd1;
          else                alarm_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mh_q     <= 4'd0;
      ml_q     <= 4'd0;
      sh_q     <= 4'd0;
      sl_q     <= 4'd0;
      borrow_q <= 1'b0;
      alarm_q  <= 1'b0;
      acnt_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      mh_q     <= mh_d;
      ml_q     <= ml_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
      borrow_q <= borrow_d;
      alarm_q  <= alarm_d;
      acnt_q   <= acnt_d;
    end
  end

  assign min_high   = mh_q;
  assign min_low    = ml_q;
  assign sec_high   = sh_q;
  assign sec_low    = sl_q;
  assign borrow_min = borrow_q;
  assign running    = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_m_cntdn_timer.sv
// Table-driven bench for m_cntdn_timer: each record is one clk_sec edge with its expected
// digits and {borrow_min, running, done, alarm}; expectations go through a scoreboard queue.
module tb_m_cntdn_timer;

  logic       clk_sec = 1'b0;
  logic       rst, load, start, pause;
  logic [3:0] min_high_in, min_low_in, sec_high_in, sec_low_in;
  logic [3:0] min_high, min_low, sec_high, sec_low;
  logic       borrow_min, running, done, alarm;

  m_cntdn_timer #(.ALARM_SECS(5)) dut (
    .clk_sec     (clk_sec),
    .rst         (rst),
    .load        (load),
    .start       (start),
    .pause       (pause),
    .min_high_in (min_high_in),
    .min_low_in  (min_low_in),
    .sec_high_in (sec_high_in),
    .sec_low_in  (sec_low_in),
    .min_high    (min_high),
    .min_low     (min_low),
    .sec_high    (sec_high),
    .sec_low     (sec_low),
    .borrow_min  (borrow_min),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  always #5 clk_sec = ~clk_sec;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic        ps;
    logic [15:0] pre;
    logic [15:0] dig;
    logic [3:0]  flg;  // {borrow_min, running, done, alarm}
  } vec_t;

  localparam logic [3:0] FIdle = 4'b0000;
  localparam logic [3:0] FRun  = 4'b0100;
  localparam logic [3:0] FBor  = 4'b1100;
  localparam logic [3:0] FDnA  = 4'b0011;
  localparam logic [3:0] FDn   = 4'b0010;

  vec_t        vecs[$];
  logic [19:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  function automatic void add(input string name, input logic ld, input logic st, input logic ps,
                              input logic [15:0] pre, input logic [15:0] dig,
                              input logic [3:0] flg);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.ps = ps; v.pre = pre; v.dig = dig; v.flg = flg;
    vecs.push_back(v);
  endfunction

  function automatic logic [19:0] outs();
    return {min_high, min_low, sec_high, sec_low, borrow_min, running, done, alarm};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got digits=%h flags=%b, expected digits=%h flags=%b",
               name, act[19:4], act[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk_sec);
    load        = v.ld;
    start       = v.st;
    pause       = v.ps;
    min_high_in = v.pre[15:12];
    min_low_in  = v.pre[11:8];
    sec_high_in = v.pre[7:4];
    sec_low_in  = v.pre[3:0];
    sb.push_back({v.dig, v.flg});
    @(posedge clk_sec);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      check(v.name, outs(), sb.pop_front());
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    min_high_in = 4'd0; min_low_in = 4'd0; sec_high_in = 4'd0; sec_low_in = 4'd0;
    #12;
    check("reset", outs(), 20'h0);
    @(negedge clk_sec);
    rst = 1'b0;

    // Basic countdown with borrow on 01:00 -> 00:59
    add("ld0102",   1, 0, 0, 16'h0102, 16'h0102, FIdle);
    add("start",    0, 1, 0, 16'h0000, 16'h0102, FRun);
    add("dec0101",  0, 0, 0, 16'h0000, 16'h0101, FRun);
    add("dec0100",  0, 0, 0, 16'h0000, 16'h0100, FRun);
    add("bor0059",  0, 0, 0, 16'h0000, 16'h0059, FBor);
    add("dec0058",  0, 0, 0, 16'h0000, 16'h0058, FRun);
    // Reaching 00:00, alarm window of 5 edges, DONE is sticky
    add("ld0003",   1, 0, 0, 16'h0003, 16'h0003, FIdle);
    add("start3",   0, 1, 0, 16'h0000, 16'h0003, FRun);
    add("dec0002",  0, 0, 0, 16'h0000, 16'h0002, FRun);
    add("dec0001",  0, 0, 0, 16'h0000, 16'h0001, FRun);
    add("done",     0, 0, 0, 16'h0000, 16'h0000, FDnA);
    add("alarm2",   0, 1, 0, 16'h0000, 16'h0000, FDnA);
    add("alarm3",   0, 0, 1, 16'h0000, 16'h0000, FDnA);
    add("alarm4",   0, 0, 0, 16'h0000, 16'h0000, FDnA);
    add("alarm5",   0, 0, 0, 16'h0000, 16'h0000, FDnA);
    add("alarmoff", 0, 0, 0, 16'h0000, 16'h0000, FDn);
    add("donestk",  0, 1, 0, 16'h0000, 16'h0000, FDn);
    // Pause / resume
    add("ld0020",   1, 0, 0, 16'h0020, 16'h0020, FIdle);
    add("start20",  0, 1, 0, 16'h0000, 16'h0020, FRun);
    add("dec0019",  0, 0, 0, 16'h0000, 16'h0019, FRun);
    add("dec0018",  0, 0, 0, 16'h0000, 16'h0018, FRun);
    add("pause1",   0, 0, 1, 16'h0000, 16'h0018, FIdle);
    add("pause2",   0, 0, 1, 16'h0000, 16'h0018, FIdle);
    add("pause3",   0, 0, 1, 16'h0000, 16'h0018, FIdle);
    add("pause4",   0, 0, 1, 16'h0000, 16'h0018, FIdle);
    add("resume",   0, 1, 0, 16'h0000, 16'h0018, FRun);
    add("dec0017",  0, 0, 0, 16'h0000, 16'h0017, FRun);
    // Saturating load, zero start ignored
    add("ldsat",    1, 0, 0, 16'h7C9F, 16'h5959, FIdle);
    add("ld0000",   1, 0, 0, 16'h0000, 16'h0000, FIdle);
    add("startz",   0, 1, 0, 16'h0000, 16'h0000, FIdle);
    add("startz2",  0, 1, 1, 16'h0000, 16'h0000, FIdle);
    // Load during RUN, minutes borrow across tens
    add("ld1000",   1, 0, 0, 16'h1000, 16'h1000, FIdle);
    add("start10",  0, 1, 0, 16'h0000, 16'h1000, FRun);
    add("ldrun",    1, 1, 0, 16'h0230, 16'h0230, FIdle);
    add("start230", 0, 1, 0, 16'h0000, 16'h0230, FRun);
    add("dec0229",  0, 0, 0, 16'h0000, 16'h0229, FRun);
    add("stpause",  0, 1, 1, 16'h0000, 16'h0229, FIdle);
    add("ld1000b",  1, 0, 0, 16'h1000, 16'h1000, FIdle);
    add("start10b", 0, 1, 0, 16'h0000, 16'h1000, FRun);
    add("bor0959",  0, 0, 0, 16'h0000, 16'h0959, FBor);
    run_table();

    // Asynchronous reset while running at 03:27
    add("ld0327",   1, 0, 0, 16'h0327, 16'h0327, FIdle);
    add("start327", 0, 1, 0, 16'h0000, 16'h0327, FRun);
    run_table();
    @(negedge clk_sec);
    load = 1'b0; start = 1'b0; pause = 1'b0;
    #2;
    check("prerst", outs(), {16'h0327, FRun});
    rst = 1'b1;
    #1;
    check("asyncrst", outs(), 20'h0);
    @(posedge clk_sec);
    #1;
    check("rsthold", outs(), 20'h0);
    @(negedge clk_sec);
    rst = 1'b0;
    add("postrst",  0, 0, 1, 16'h0000, 16'h0000, FIdle);
    run_table();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
